// File: rtl/reg_write_arbiter_if.sv
// Write-path bundle between requesters and the register-write arbiter.
// master: requester side (drives req/addr/data); slave: arbiter side.
interface reg_write_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned NUM_REG = 8,
  parameter int unsigned ADDR_W  = 3,
  parameter int unsigned DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        ack;
  logic [NUM_REG-1:0]        wr_load;
  logic [DATA_W-1:0]         wr_data;
  logic                      busy;
  logic                      addr_err;

  modport master (
    output req, req_addr, req_data,
    input  ack, wr_load, wr_data, busy, addr_err
  );

  modport slave (
    input  req, req_addr, req_data,
    output ack, wr_load, wr_data, busy, addr_err
  );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one write path into a bank of load-enable registers.
// Optional macro ARB_PRIO0_EN: requester 0 gets fixed highest priority and does
// not advance the round-robin pointer.
module reg_write_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned NUM_REG = 8,
  parameter int unsigned ADDR_W  = 3,
  parameter int unsigned DATA_W  = 32
) (
  input logic               clk,
  input logic               reset,
  reg_write_arbiter_if.slave bus
);
  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [NUM_REG-1:0] wr_load_q, wr_load_d;
  logic [DATA_W-1:0]  wr_data_q, wr_data_d;
  logic               addr_err_q, addr_err_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;

  logic [NUM_REQ-1:0] eligible;
  logic               grant_valid;
  logic [PTR_W-1:0]   grant_idx;
  logic [ADDR_W-1:0]  grant_addr;
  int unsigned        idx;

  // The registered ack masks the winner for one cycle so a held req is not
  // granted twice in a row.
  assign eligible = bus.req & ~ack_q;

  // Pick the first eligible requester starting at ptr, wrapping around.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_valid && eligible[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = PTR_W'(idx);
      end
    end
`ifdef ARB_PRIO0_EN
    if (eligible[0]) begin
      grant_valid = 1'b1;
      grant_idx   = '0;
    end
`endif
  end

  // Next-state for the registered write port, ack and pointer.
  always_comb begin
    ack_d      = '0;
    wr_load_d  = '0;
    wr_data_d  = wr_data_q;
    addr_err_d = 1'b0;
    ptr_d      = ptr_q;
    grant_addr = '0;
    if (grant_valid) begin
      grant_addr       = bus.req_addr[grant_idx*ADDR_W +: ADDR_W];
      wr_data_d        = bus.req_data[grant_idx*DATA_W +: DATA_W];
      ack_d[grant_idx] = 1'b1;
      // Out-of-range indices match no bit, leaving wr_load all zero.
      for (int unsigned r = 0; r < NUM_REG; r++) begin
        wr_load_d[r] = (32'(grant_addr) == r);
      end
      addr_err_d = (32'(grant_addr) >= NUM_REG);
`ifdef ARB_PRIO0_EN
      if (grant_idx != '0) begin
        ptr_d = (32'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
      end
`else
      ptr_d = (32'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
`endif
    end
  end

  // State registers; reset drops any in-flight grant immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_q      <= '0;
      wr_load_q  <= '0;
      wr_data_q  <= '0;
      addr_err_q <= 1'b0;
      ptr_q      <= '0;
    end else begin
      ack_q      <= ack_d;
      wr_load_q  <= wr_load_d;
      wr_data_q  <= wr_data_d;
      addr_err_q <= addr_err_d;
      ptr_q      <= ptr_d;
    end
  end

  assign bus.ack      = ack_q;
  assign bus.wr_load  = wr_load_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.addr_err = addr_err_q;
  assign bus.busy     = |eligible;
endmodule
